// File: rtl/serializer_ms_pkg.sv
// Shared types and helpers for the multi-length serializer.
// State encoding and the mod-to-length decode used at word acceptance.
package serializer_ms_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      PARITY = 2'd2
   } ser_state_e;

   // A mod of 0 selects a full word; out-of-range values saturate to the word width.
   function automatic int unsigned decode_len(input int unsigned mod_val,
                                              input int unsigned data_w);
      if (mod_val == 0 || mod_val > data_w) begin
         return data_w;
      end
      return mod_val;
   endfunction

endpackage

// File: rtl/serializer_ms_if.sv
// Word-side and bit-side handshake bundle for serializer_ms.
// The slave modport is the serializer; master is the producer/consumer side.
interface serializer_ms_if #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
);

   logic [DATA_W-1:0] data_i;
   logic [MOD_W-1:0]  data_mod_i;
   logic              msb_first_i;
   logic              data_val_i;
   logic              data_rdy_o;
   logic              ser_data_o;
   logic              ser_data_val_o;
   logic              ser_rdy_i;
   logic              busy_o;

   modport slave (
      input  data_i,
      input  data_mod_i,
      input  msb_first_i,
      input  data_val_i,
      input  ser_rdy_i,
      output data_rdy_o,
      output ser_data_o,
      output ser_data_val_o,
      output busy_o
   );

   modport master (
      output data_i,
      output data_mod_i,
      output msb_first_i,
      output data_val_i,
      output ser_rdy_i,
      input  data_rdy_o,
      input  ser_data_o,
      input  ser_data_val_o,
      input  busy_o
   );

endinterface

// File: rtl/serializer_ms_shreg.sv
// Loadable shift register with per-word direction; holds while neither load nor shift.
// head_o is the bit that goes out next in the captured direction.
module serializer_ms_shreg #(
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              arst_ni,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic              msb_first_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              head_o
);

   logic [DATA_W-1:0] sh_q, sh_d;
   logic              msb_q, msb_d;

   // Load wins over shift so a new word can replace the last bit of the old one.
   always_comb begin
      sh_d  = sh_q;
      msb_d = msb_q;
      if (load_i) begin
         sh_d  = data_i;
         msb_d = msb_first_i;
      end else if (shift_i) begin
         if (msb_q) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
         end else begin
            sh_d = {1'b0, sh_q[DATA_W-1:1]};
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         sh_q  <= '0;
         msb_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         msb_q <= msb_d;
      end
   end

   assign head_o = msb_q ? sh_q[DATA_W-1] : sh_q[0];

endmodule

// File: rtl/serializer_ms.sv
// Parallel-to-serial converter with ready/valid input, output backpressure and per-word length.
// Optional feature macro SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module serializer_ms
   import serializer_ms_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int MOD_W   = $clog2(DATA_W),
   parameter int MIN_LEN = 1
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   serializer_ms_if.slave bus
);

   localparam int          CNT_W     = $clog2(DATA_W + 1);
   localparam int unsigned MIN_LEN_U = MIN_LEN;

   ser_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MOD_W-1:0]  mod_w;
   int unsigned       len_int;
   logic [CNT_W-1:0]  len_in;
   logic              len_ok;
   logic              data_rdy;
   logic              accept;
   logic              consume;
   logic              start;
   logic              last_beat;
   logic              load;
   logic              shift;
   logic              head;
   logic              ser_bit;
   logic              ser_val;
`ifdef SERIALIZER_PARITY_EN
   logic              par_q, par_d;
`endif

   assign mod_w   = bus.data_mod_i;
   assign len_int = decode_len(32'(mod_w), DATA_W);
   assign len_in  = CNT_W'(len_int);
   assign len_ok  = (len_int >= MIN_LEN_U);

   // The final beat of a word is the only place a new word may overlap the old one.
`ifdef SERIALIZER_PARITY_EN
   assign last_beat = (state_q == PARITY);
`else
   assign last_beat = (state_q == SEND) && (cnt_q == CNT_W'(1));
`endif

   assign ser_val  = (state_q != IDLE);
   assign data_rdy = (state_q == IDLE) | (last_beat & bus.ser_rdy_i);
   assign accept   = bus.data_val_i & data_rdy;
   assign consume  = ser_val & bus.ser_rdy_i;
   assign start    = accept & len_ok;

   serializer_ms_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk_i       (clk_i),
      .arst_ni     (arst_ni),
      .load_i      (load),
      .shift_i     (shift),
      .msb_first_i (bus.msb_first_i),
      .data_i      (bus.data_i),
      .head_o      (head)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      shift   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         SEND: begin
            if (consume) begin
               shift = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
               par_d = par_q ^ head;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = PARITY;
               end
`else
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (consume) begin
               state_d = IDLE;
            end
         end
`endif
         default: ;
      endcase
      // Short words are accepted but never start a transfer.
      if (start) begin
         load    = 1'b1;
         cnt_d   = len_in;
         state_d = SEND;
`ifdef SERIALIZER_PARITY_EN
         par_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SERIALIZER_PARITY_EN
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   always_comb begin
      ser_bit = 1'b0;
      if (state_q == SEND) begin
         ser_bit = head;
      end
`ifdef SERIALIZER_PARITY_EN
      else if (state_q == PARITY) begin
         ser_bit = par_q;
      end
`endif
   end

   assign bus.ser_data_o     = ser_bit;
   assign bus.ser_data_val_o = ser_val;
   assign bus.data_rdy_o     = data_rdy;
   assign bus.busy_o         = ser_val;

endmodule

// File: tb/tb_serializer_ms.sv
// Directed bench for serializer_ms: full-word, short-word, stall, drop, reset and parity cases.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_serializer_ms;

   localparam int DW = 16;
   localparam int MW = 4;
`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst_n;

   always #5 clk = ~clk;

   serializer_ms_if #(.DATA_W(DW), .MOD_W(MW)) bus ();
   serializer_ms_if #(.DATA_W(DW), .MOD_W(MW)) bus4 ();

   serializer_ms #(.DATA_W(DW), .MOD_W(MW), .MIN_LEN(1)) u_dut (
      .clk_i   (clk),
      .arst_ni (arst_n),
      .bus     (bus)
   );

   serializer_ms #(.DATA_W(DW), .MOD_W(MW), .MIN_LEN(4)) u_dut4 (
      .clk_i   (clk),
      .arst_ni (arst_n),
      .bus     (bus4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic slot();
      @(negedge clk);
   endtask

   task automatic offer(input logic [15:0] d, input logic [3:0] m, input logic msb);
      bus.data_i      = d;
      bus.data_mod_i  = m;
      bus.msb_first_i = msb;
      bus.data_val_i  = 1'b1;
   endtask

   task automatic offer4(input logic [15:0] d, input logic [3:0] m, input logic msb);
      bus4.data_i      = d;
      bus4.data_mod_i  = m;
      bus4.msb_first_i = msb;
      bus4.data_val_i  = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_val"},  bus.ser_data_val_o, 1'b0);
      chk({tag, "_busy"}, bus.busy_o,         1'b0);
      chk({tag, "_rdy"},  bus.data_rdy_o,     1'b1);
   endtask

   logic [15:0] t1_exp;
   logic [4:0]  t2_exp;
   logic        t3_rdy_pat [6];
   logic        t3_bit     [6];
   logic        t3_rdy     [6];
   logic [3:0]  t4_exp;
   logic [15:0] t5_exp;

   initial begin
      t1_exp     = 16'b1010_0101_1100_0011;
      t2_exp     = 5'b10001;
      t3_rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      t3_bit     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      t3_rdy     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !PAR_EN};
      t4_exp     = 4'b1010;
      t5_exp     = 16'b1100_0000_0000_0001;

      arst_n = 1'b0;
      bus.data_i = '0;  bus.data_mod_i = '0;  bus.msb_first_i = 1'b0;
      bus.data_val_i = 1'b0;  bus.ser_rdy_i = 1'b1;
      bus4.data_i = '0; bus4.data_mod_i = '0; bus4.msb_first_i = 1'b0;
      bus4.data_val_i = 1'b0; bus4.ser_rdy_i = 1'b1;

      // Reset values
      slot(); #1;
      chk("rst_data", bus.ser_data_o, 1'b0);
      chk_idle("rst");
      slot(); arst_n = 1'b1;

      // Full 16-bit word, MSB first
      slot(); offer(16'hA5C3, 4'd0, 1'b1); #1;
      chk("t1_rdy_idle", bus.data_rdy_o, 1'b1);
      for (int i = 0; i < 16; i++) begin
         slot(); bus.data_val_i = 1'b0; #1;
         chk("t1_val", bus.ser_data_val_o, 1'b1);
         chk("t1_bit", bus.ser_data_o, t1_exp[15-i]);
         chk("t1_rdy", bus.data_rdy_o, (i == 15) && !PAR_EN);
      end
`ifdef SERIALIZER_PARITY_EN
      slot(); #1;
      chk("t1_par", bus.ser_data_o, 1'b0);
      chk("t1_par_val", bus.ser_data_val_o, 1'b1);
`endif
      slot(); #1;
      chk_idle("t1_end");

      // 5-bit LSB-first word, next word accepted on the final beat
      slot(); offer(16'h00F1, 4'd5, 1'b0); #1;
      for (int i = 0; i < 5; i++) begin
         slot();
         bus.data_val_i = 1'b0;
         if (i == 4 && !PAR_EN) offer(16'h8000, 4'd2, 1'b1);
         #1;
         chk("t2_val", bus.ser_data_val_o, 1'b1);
         chk("t2_bit", bus.ser_data_o, t2_exp[i]);
         chk("t2_rdy", bus.data_rdy_o, (i == 4) && !PAR_EN);
      end
`ifdef SERIALIZER_PARITY_EN
      slot(); offer(16'h8000, 4'd2, 1'b1); #1;
      chk("t2_par", bus.ser_data_o, 1'b0);
      chk("t2_par_rdy", bus.data_rdy_o, 1'b1);
`endif
      slot(); bus.data_val_i = 1'b0; #1;
      chk("t2_w2_val0", bus.ser_data_val_o, 1'b1);
      chk("t2_w2_bit0", bus.ser_data_o, 1'b1);
      slot(); #1;
      chk("t2_w2_bit1", bus.ser_data_o, 1'b0);
`ifdef SERIALIZER_PARITY_EN
      slot(); #1;
      chk("t2_w2_par", bus.ser_data_o, 1'b1);
`endif
      slot(); #1;
      chk_idle("t2_end");

      // 3-bit word under backpressure
      slot(); offer(16'h0005, 4'd3, 1'b0); #1;
      for (int i = 0; i < 6; i++) begin
         slot();
         bus.data_val_i = 1'b0;
         bus.ser_rdy_i  = t3_rdy_pat[i];
         #1;
         chk("t3_val", bus.ser_data_val_o, 1'b1);
         chk("t3_bit", bus.ser_data_o, t3_bit[i]);
         chk("t3_rdy", bus.data_rdy_o, t3_rdy[i]);
      end
`ifdef SERIALIZER_PARITY_EN
      slot(); bus.ser_rdy_i = 1'b0; #1;
      chk("t3_par_stall_rdy", bus.data_rdy_o, 1'b0);
      slot(); bus.ser_rdy_i = 1'b1; #1;
      chk("t3_par", bus.ser_data_o, 1'b0);
      chk("t3_par_rdy", bus.data_rdy_o, 1'b1);
`endif
      slot(); bus.ser_rdy_i = 1'b1; #1;
      chk_idle("t3_end");

      // MIN_LEN=4 instance: short word dropped, len==MIN_LEN sent
      slot(); offer4(16'hFFFF, 4'd2, 1'b0); #1;
      chk("t4_rdy", bus4.data_rdy_o, 1'b1);
      for (int i = 0; i < 2; i++) begin
         slot(); bus4.data_val_i = 1'b0; #1;
         chk("t4_drop_val",  bus4.ser_data_val_o, 1'b0);
         chk("t4_drop_busy", bus4.busy_o,         1'b0);
      end
      slot(); offer4(16'h000A, 4'd4, 1'b0); #1;
      chk("t4_min_rdy", bus4.data_rdy_o, 1'b1);
      for (int i = 0; i < 4; i++) begin
         slot(); bus4.data_val_i = 1'b0; #1;
         chk("t4_min_val", bus4.ser_data_val_o, 1'b1);
         chk("t4_min_bit", bus4.ser_data_o, t4_exp[i]);
      end
`ifdef SERIALIZER_PARITY_EN
      slot(); #1;
      chk("t4_par", bus4.ser_data_o, 1'b0);
`endif
      slot(); #1;
      chk("t4_end_busy", bus4.busy_o, 1'b0);

      // Reset during the 7th bit, then a clean word
      slot(); offer(16'hFFFF, 4'd0, 1'b1); #1;
      for (int i = 0; i < 7; i++) begin
         slot(); bus.data_val_i = 1'b0; #1;
         chk("t5_pre_bit", bus.ser_data_o, 1'b1);
      end
      arst_n = 1'b0; #1;
      chk("t5_rst_data", bus.ser_data_o, 1'b0);
      chk_idle("t5_rst");
      offer(16'hFFFF, 4'd0, 1'b1);
      slot(); #1;
      chk("t5_rst_hold_val", bus.ser_data_val_o, 1'b0);
      bus.data_val_i = 1'b0;
      arst_n = 1'b1;
      slot(); #1;
      chk_idle("t5_post");
      slot(); offer(16'hC001, 4'd0, 1'b1); #1;
      for (int i = 0; i < 16; i++) begin
         slot(); bus.data_val_i = 1'b0; #1;
         chk("t5_val", bus.ser_data_val_o, 1'b1);
         chk("t5_bit", bus.ser_data_o, t5_exp[15-i]);
      end
`ifdef SERIALIZER_PARITY_EN
      slot(); #1;
      chk("t5_par", bus.ser_data_o, 1'b1);
`endif
      slot(); #1;
      chk_idle("t5_end");

`ifdef SERIALIZER_PARITY_EN
      // Parity after 3 ones, LSB first
      slot(); offer(16'h0007, 4'd3, 1'b0); #1;
      for (int i = 0; i < 4; i++) begin
         slot(); bus.data_val_i = 1'b0; #1;
         chk("t6_val", bus.ser_data_val_o, 1'b1);
         chk("t6_bit", bus.ser_data_o, 1'b1);
      end
      slot(); #1;
      chk_idle("t6_end");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serializer_ms.md
# serializer_ms

Parametrised successor to the team's single-word serializer. Accepts a parallel word of DATA_W bits with a per-word valid length and bit order, and emits it one bit per cycle on a serial stream. Adds three things:
- a ready/valid input handshake with gapless back-to-back words;
- output backpressure;
- arbitrary lengths down to MIN_LEN.

It sits between a word-oriented producer and a bit-serial line encoder.

## Interface
Parameters:
- DATA_W, 16, parallel word width; must be ≥ 2.
- MOD_W, $clog2(DATA_W), width of data_mod_i.
- MIN_LEN, 1, shortest length transmitted; shorter words are dropped.

Ports:
- clk_i  in  1  single clock; everything is on the rising edge.
- arst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  DATA_W  parallel word.
- data_mod_i  in  MOD_W  number of valid bits; 0 means DATA_W.
- msb_first_i  in  1  bit order: 1 = MSB first, 0 = LSB first.
- data_val_i  in  1  input word valid.
- data_rdy_o  out  1  block can accept a word this cycle.
- ser_data_o  out  1  serial data bit.
- ser_data_val_o  out  1  ser_data_o is valid.
- ser_rdy_i  in  1  downstream consumes the bit this cycle.
- busy_o  out  1  a word is in flight (state ≠ IDLE).

## Operation
Handshakes:
- Word accepted ⇔ data_val_i & data_rdy_o.
- Bit consumed ⇔ ser_data_val_o & ser_rdy_i.

Length and dropping:
- len = (data_mod_i == 0) ? DATA_W : data_mod_i.
- A word with len < MIN_LEN is still accepted, but produces no output and does not leave IDLE.

Bit order:
- MSB first sends data_i[DATA_W-1] down to data_i[DATA_W-len].
- LSB first sends data_i[0] up to data_i[len-1].
- Implementation: the word is captured into a shift register (shifts left for MSB first, right for LSB first). A remaining-bit counter of width $clog2(DATA_W+1) is loaded with len.

States:
- IDLE: ser_data_val_o=0, data_rdy_o=1. An accepted word with len ≥ MIN_LEN → SEND.
- SEND: ser_data_val_o=1, ser_data_o = current head bit.
  - On consume: shift and decrement the counter.
  - On consuming the last bit (counter==1):
    - → PARITY if SERIALIZER_PARITY_EN is defined;
    - else → SEND with the new word, if one is accepted in the same cycle;
    - else → IDLE.
  - Without consume: hold data and counter unchanged.
- PARITY (macro only): ser_data_o = even parity of the len transmitted bits, ser_data_val_o=1.
  - On consume: → SEND with the new word if one is accepted in the same cycle, else → IDLE.

data_rdy_o:
- 1 in IDLE.
- In SEND on the last bit, or in PARITY, equals ser_rdy_i.
- Otherwise 0.
- This is the only combinational path: ser_rdy_i → data_rdy_o.

Reset:
- Asserting arst_ni mid-word immediately clears state to IDLE, counter to 0, shift register to 0 and parity to 0. The in-flight word is lost.
- Output values while arst_ni is low: ser_data_o=0, ser_data_val_o=0, busy_o=0, data_rdy_o=1. Words offered during reset are ignored.

## Timing
- Word accepted at edge N → first bit valid in cycle N+1. Latency is 1 cycle; ser_data_o and ser_data_val_o are registered.
- Without stalls, a word occupies exactly len cycles, or len+1 with parity.
- Back-to-back words need no idle gap: the first bit of word k+1 directly follows the last bit (or parity bit) of word k.
- Stall (ser_rdy_i=0) holds ser_data_o, ser_data_val_o and the counter unchanged for any number of cycles.
- msb_first_i and data_mod_i are sampled only at acceptance. Changing them mid-word has no effect.
- len == DATA_W (mod 0) and len == 1 are both legal when ≥ MIN_LEN.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - adds the PARITY state;
  - appends one even-parity bit after every transmitted word;
  - the parity bit obeys ser_rdy_i like any data bit.
- Undefined: no PARITY state and no parity register; words are exactly len bits.

## Structure
- Package serializer_ms_pkg holds:
  - the state enum (IDLE, SEND, PARITY);
  - a len-decode function (mod → len, 0 ⇒ DATA_W).
- One sub-module is natural: serializer_ms_shreg, a loadable, direction-selectable, hold-on-stall shift register that exposes its head bit.

## Test plan
- DATA_W=16, data_i=16'hA5C3, mod=0, msb_first=1, ser_rdy_i=1 → bits 1010010111000011 on cycles N+1…N+16, then busy_o=0.
- data_i=16'h00F1, mod=5, msb_first=0 → bits 1,0,0,0,1 over 5 cycles. A second word accepted on the last-bit cycle gives its first bit at the very next cycle, with no gap.
- ser_rdy_i toggled 1,0,0,1 during a mod=3 word → each bit held while stalled; data_rdy_o=0 except on the last-bit cycle when ser_rdy_i=1.
- MIN_LEN=4, mod=2, data_val_i=1 → accepted (data_rdy_o=1), no ser_data_val_o, busy_o stays 0.
- Reset pulse at the 7th bit of a 16-bit word → all outputs as specified at reset on the same cycle; the next word starts cleanly from its first bit.
- SERIALIZER_PARITY_EN, data_i=16'h0007, mod=3, msb_first=0 → bits 1,1,1 then parity 1; total 4 valid cycles.
